// File: rtl/mem_input_queue_if.sv
// Handshake/bus bundle between the execute stage, the input queue and the
// memory stage. The queue itself uses the slave modport.
interface mem_input_queue_if #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 3
);
  // Execute side (into the queue)
  logic             valid_i;
  logic [63:0]      data_i;
  logic [9:0]       commands_i;
  logic [TAG_W-1:0] tag_i;
  logic [3:0]       flags_i;
  logic             flush_i;
  logic             ready_o;

  // Memory side (out of the queue)
  logic             valid_o;
  logic             memReady_i;
  logic [63:0]      dataOut_o;
  logic [9:0]       commandsOut_o;
  logic [TAG_W-1:0] tagOut_o;
  logic [3:0]       flagsOut_o;

  // Status
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;

  modport slave (
    input  valid_i, data_i, commands_i, tag_i, flags_i, flush_i, memReady_i,
    output ready_o, valid_o, dataOut_o, commandsOut_o, tagOut_o, flagsOut_o,
           count_o, overflow_o
  );

  modport master (
    output valid_i, data_i, commands_i, tag_i, flags_i, flush_i, memReady_i,
    input  ready_o, valid_o, dataOut_o, commandsOut_o, tagOut_o, flagsOut_o,
           count_o, overflow_o
  );
endinterface

// File: rtl/mem_input_queue.sv
// Execute-to-memory input queue: a DEPTH-entry circular FIFO holding
// execute results (data, commands, ROB tag, flags) until the memory stage
// takes them. No bypass path, so a fresh entry appears one cycle after it
// is written. ready_o depends only on registered occupancy, so the
// execute-side arbiter never sees a path from memReady_i.
module mem_input_queue #(
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int DEPTH      = 4
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  mem_input_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; never reset, gated off the outputs while empty.
  logic [63:0]           data_mem  [DEPTH];
  logic [9:0]            cmd_mem   [DEPTH];
  logic [ROBsizeLog-1:0] tag_mem   [DEPTH];
  logic [3:0]            flags_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic ready;
  logic not_empty;
  logic enq;
  logic deq;

  // Handshake qualification; flush overrides both directions.
  always_comb begin
    ready     = (count_q != FULL_CNT);
    not_empty = (count_q != '0);
    enq       = bus.valid_i && ready && !bus.flush_i;
    deq       = not_empty && bus.memReady_i && !bus.flush_i;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.flush_i) begin
      // Flush empties the queue but is not an overflow, even with valid_i up.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // A full queue rejects new data even when the head leaves this cycle.
      if (bus.valid_i && !ready) overflow_d = 1'b1;
    end
  end

  // Control state, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry write at the write pointer on an accepted enqueue.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_mem[wr_ptr_q]  <= bus.data_i;
      cmd_mem[wr_ptr_q]   <= bus.commands_i;
      tag_mem[wr_ptr_q]   <= bus.tag_i;
      flags_mem[wr_ptr_q] <= bus.flags_i;
    end
  end

  // Head entry presented from registered state; zeroed while empty.
  always_comb begin
    bus.ready_o       = ready;
    bus.valid_o       = not_empty;
    bus.count_o       = count_q;
    bus.overflow_o    = overflow_q;
    bus.dataOut_o     = '0;
    bus.commandsOut_o = '0;
    bus.tagOut_o      = '0;
    bus.flagsOut_o    = '0;
    if (not_empty) begin
      bus.dataOut_o     = data_mem[rd_ptr_q];
      bus.commandsOut_o = cmd_mem[rd_ptr_q];
      bus.tagOut_o      = tag_mem[rd_ptr_q];
      bus.flagsOut_o    = flags_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_mem_input_queue.sv
// Bench for mem_input_queue: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_mem_input_queue;

  localparam int ROBSIZE = 16;
  localparam int TAG_W   = $clog2(ROBSIZE + 1);
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_input_queue_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  mem_input_queue #(
    .ROBsize(ROBSIZE),
    .ROBsizeLog(TAG_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      data;
    logic [9:0]       cmd;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
  } ent_t;

  // Reference model: a plain FIFO of entries plus the sticky flag.
  ent_t mq[$];
  bit   m_ovf = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  ent_t cmp_head;
  always @(negedge clk) begin
    cmp_head = '0;
    if (mq.size() != 0) cmp_head = mq[0];
    chk("cmp_valid_o",    64'(bus.valid_o),       64'(mq.size() != 0));
    chk("cmp_ready_o",    64'(bus.ready_o),       64'(mq.size() != DEPTH));
    chk("cmp_count_o",    64'(bus.count_o),       64'(mq.size()));
    chk("cmp_overflow_o", 64'(bus.overflow_o),    64'(m_ovf));
    chk("cmp_dataOut",    bus.dataOut_o,          cmp_head.data);
    chk("cmp_cmdOut",     64'(bus.commandsOut_o), 64'(cmp_head.cmd));
    chk("cmp_tagOut",     64'(bus.tagOut_o),      64'(cmp_head.tag));
    chk("cmp_flagsOut",   64'(bus.flagsOut_o),    64'(cmp_head.flags));
  end

  task automatic drive(input bit v, input int tag, input logic [63:0] data,
                       input bit mr, input bit fl);
    bus.valid_i    = v;
    bus.tag_i      = TAG_W'(tag);
    bus.data_i     = data;
    bus.commands_i = 10'($urandom);
    bus.flags_i    = 4'($urandom);
    bus.memReady_i = mr;
    bus.flush_i    = fl;
  endtask

  // One clock: the model takes the same inputs the DUT sees at the edge.
  task automatic step();
    ent_t e;
    int   n;
    @(posedge clk);
    e.data  = bus.data_i;
    e.cmd   = bus.commands_i;
    e.tag   = bus.tag_i;
    e.flags = bus.flags_i;
    n = mq.size();
    if (reset_n) begin
      if (bus.flush_i) begin
        $display("flush discarded=%0d", n);
        mq.delete();
      end else begin
        if (bus.valid_i && n == DEPTH) begin
          m_ovf = 1'b1;
          $display("drop tag=%0d (full)", e.tag);
        end
        if (n != 0 && bus.memReady_i) begin
          $display("deq tag=%0d data=0x%0h", mq[0].tag, mq[0].data);
          void'(mq.pop_front());
        end
        if (bus.valid_i && n != DEPTH) begin
          $display("enq tag=%0d data=0x%0h", e.tag, e.data);
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  // Reset pulled low between edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    #1;
    $display("async reset asserted");
    chk("rst_count_o", 64'(bus.count_o),    64'd0);
    chk("rst_valid_o", 64'(bus.valid_o),    64'd0);
    chk("rst_ready_o", 64'(bus.ready_o),    64'd1);
    chk("rst_ovf_o",   64'(bus.overflow_o), 64'd0);
    chk("rst_tagOut",  64'(bus.tagOut_o),   64'd0);
    chk("rst_dataOut", bus.dataOut_o,       64'd0);
    drive(0, 0, 64'd0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  int exp_tags[12];

  initial begin
    drive(0, 0, 64'd0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("reset_valid", 64'(bus.valid_o),    64'd0);
    chk("reset_ready", 64'(bus.ready_o),    64'd1);
    chk("reset_count", 64'(bus.count_o),    64'd0);
    chk("reset_ovf",   64'(bus.overflow_o), 64'd0);

    // Single entry, held while memory is stalled.
    drive(1, 3, 64'hAA, 0, 0);
    step();
    drive(0, 0, 64'd0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk("hold_valid", 64'(bus.valid_o),  64'd1);
      chk("hold_tag",   64'(bus.tagOut_o), 64'd3);
      chk("hold_data",  bus.dataOut_o,     64'hAA);
      chk("hold_count", 64'(bus.count_o),  64'd1);
      if (c < 2) step();
    end
    drive(0, 0, 64'd0, 0, 1);
    step();
    chk("flush1_count", 64'(bus.count_o), 64'd0);

    // Fill, overflow, drain in order.
    for (int t = 1; t <= 4; t++) begin
      drive(1, t, 64'(t * 16), 0, 0);
      step();
    end
    chk("full_count", 64'(bus.count_o),    64'd4);
    chk("full_ready", 64'(bus.ready_o),    64'd0);
    chk("full_ovf",   64'(bus.overflow_o), 64'd0);
    drive(1, 5, 64'h55, 0, 0);
    step();
    chk("drop_ovf",   64'(bus.overflow_o), 64'd1);
    chk("drop_count", 64'(bus.count_o),    64'd4);
    drive(0, 0, 64'd0, 1, 0);
    for (int t = 1; t <= 4; t++) begin
      chk("drain_tag", 64'(bus.tagOut_o), 64'(t));
      step();
    end
    chk("empty_valid", 64'(bus.valid_o),  64'd0);
    chk("empty_tag",   64'(bus.tagOut_o), 64'd0);
    chk("empty_data",  bus.dataOut_o,     64'd0);

    // Full with simultaneous valid and memReady: dequeue only.
    for (int t = 10; t <= 13; t++) begin
      drive(1, t, 64'(t), 0, 0);
      step();
    end
    drive(1, 14, 64'd14, 1, 0);
    step();
    chk("fullrw_count", 64'(bus.count_o),    64'd3);
    chk("fullrw_ovf",   64'(bus.overflow_o), 64'd1);
    chk("fullrw_tag",   64'(bus.tagOut_o),   64'd11);
    drive(0, 0, 64'd0, 1, 0);
    step();
    chk("two_count", 64'(bus.count_o), 64'd2);
    exp_tags[0] = 12;
    exp_tags[1] = 13;
    for (int k = 0; k < 10; k++) exp_tags[k + 2] = 20 + k;
    for (int k = 0; k < 10; k++) begin
      chk("stream_tag", 64'(bus.tagOut_o), 64'(exp_tags[k]));
      drive(1, 20 + k, 64'(k), 1, 0);
      step();
      chk("stream_count", 64'(bus.count_o), 64'd2);
    end
    chk("stream_head", 64'(bus.tagOut_o), 64'd28);

    // Flush wins over valid and memReady.
    drive(1, 30, 64'd30, 0, 0);
    step();
    chk("pre_flush_count", 64'(bus.count_o), 64'd3);
    drive(1, 31, 64'd31, 1, 1);
    step();
    chk("flush_count", 64'(bus.count_o),    64'd0);
    chk("flush_valid", 64'(bus.valid_o),    64'd0);
    chk("flush_ready", 64'(bus.ready_o),    64'd1);
    chk("flush_ovf",   64'(bus.overflow_o), 64'd1);

    // After reset: flushing a full queue with valid_i up is not an overflow.
    async_reset();
    for (int t = 50; t <= 53; t++) begin
      drive(1, t, 64'(t), 0, 0);
      step();
    end
    drive(1, 54, 64'd54, 0, 1);
    step();
    chk("fullflush_ovf",   64'(bus.overflow_o), 64'd0);
    chk("fullflush_count", 64'(bus.count_o),    64'd0);

    // Mid-operation reset, then enqueue from empty.
    drive(1, 40, 64'd40, 0, 0);
    step();
    drive(1, 41, 64'd41, 0, 0);
    step();
    chk("pre_rst_count", 64'(bus.count_o), 64'd2);
    async_reset();
    drive(1, 7, 64'h77, 0, 0);
    step();
    chk("post_rst_valid", 64'(bus.valid_o),  64'd1);
    chk("post_rst_tag",   64'(bus.tagOut_o), 64'd7);
    chk("post_rst_count", 64'(bus.count_o),  64'd1);

    // Randomized traffic alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 1500; i++) begin
      bit v, mr, fl;
      v  = ($urandom_range(0, 3) != 0);
      if (((i / 200) % 2) == 0) mr = ($urandom_range(0, 3) == 0);
      else                      mr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end
      drive(v, int'($urandom_range(0, ROBSIZE)), {$urandom, $urandom}, mr, fl);
      step();
    end

    drive(0, 0, 64'd0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
